// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction prefetch with an in-order response queue and redirect flush.
// Define IFU_PERF_EN to add saturating fetched/discarded/stall counters.
module ifu_prefetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_taken,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  id_ready,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc_plus4
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_discarded,
    output logic [31:0]           perf_stall
`endif
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, tgt;
    logic [CW-1:0]         outstanding_q, outstanding_d, discard_q, discard_d, count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] mem_pc [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_instr [FIFO_DEPTH];
    logic                  has_head, req_fire, pop, push, drop;

    always_comb begin
        has_head       = count_q != '0;
        tgt            = redirect_addr & ~ADDR_WIDTH'(3);
        // credit check: in-flight plus buffered never exceeds the queue, so pushes cannot overflow
        imem_req_valid = (state_q != BOOT) && !redirect_taken &&
                         (({1'b0, outstanding_q} + {1'b0, count_q}) < CW1'(FIFO_DEPTH));
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        if_valid       = has_head && !redirect_taken;
        pop            = if_valid && id_ready;
        drop           = imem_rsp_valid && (redirect_taken || discard_q != '0);
        push           = imem_rsp_valid && !drop;
        if_pc          = has_head ? mem_pc[rd_ptr_q] : '0;
        if_instr       = has_head ? mem_instr[rd_ptr_q] : '0;
        if_pc_plus4    = has_head ? mem_pc[rd_ptr_q] + ADDR_WIDTH'(4) : '0;
        fetch_pc_d     = redirect_taken ? tgt : fetch_pc_q + (req_fire ? ADDR_WIDTH'(4) : '0);
        rsp_pc_d       = redirect_taken ? tgt : rsp_pc_q + (push ? ADDR_WIDTH'(4) : '0);
        outstanding_d  = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        discard_d      = redirect_taken ? outstanding_q - CW'(imem_rsp_valid) : discard_q - CW'(drop);
        count_d        = redirect_taken ? '0 : count_q + CW'(push) - CW'(pop);
        rd_ptr_d       = redirect_taken ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d       = redirect_taken ? '0 : wr_ptr_q + PW'(push);
        state_d        = (discard_d != '0) ? FLUSH : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q]    <= rsp_pc_q;
            mem_instr[wr_ptr_q] <= imem_rsp_data;
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_discarded_q, perf_discarded_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d   = perf_fetched_q + 32'(push && perf_fetched_q != '1);
        perf_discarded_d = perf_discarded_q + 32'(drop && perf_discarded_q != '1);
        perf_stall_d     = perf_stall_q + 32'(if_valid && !id_ready && perf_stall_q != '1);
        perf_fetched     = perf_fetched_q;
        perf_discarded   = perf_discarded_q;
        perf_stall       = perf_stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
            perf_stall_q     <= '0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_discarded_q <= perf_discarded_d;
            perf_stall_q     <= perf_stall_d;
        end
    end
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed stimulus with a latency-configurable memory model and a PC-order scoreboard.
module tb_ifu_prefetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_taken, imem_req_valid, imem_req_ready, imem_rsp_valid, id_ready, if_valid;
    logic [31:0] redirect_addr, imem_req_addr, imem_rsp_data, if_pc, if_instr, if_pc_plus4;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched, perf_discarded, perf_stall;
`endif

    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    int          cyc = 0;
    int          lat = 1;
    int          exp_disc = 0;
    bit          rdy_toggle = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    ifu_prefetch dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_taken(redirect_taken), .redirect_addr(redirect_addr),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_ready(id_ready), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_pc_plus4(if_pc_plus4)
`ifdef IFU_PERF_EN
        , .perf_fetched(perf_fetched), .perf_discarded(perf_discarded), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return ~a ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic new_seq(input logic [31:0] s);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(s + 32'(4 * i));
    endtask

    task automatic wait_pops(input int n);
        int start = pops;
        int t = 0;
        while (pops - start < n && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("pop_count", 32'(pops - start), 32'(n));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc4", if_pc_plus4, 0);
    endtask

    // called at posedge+1; returns at the negedge of the cycle after the redirect
    task automatic do_redirect(input logic [31:0] addr, input logic [31:0] aligned);
        redirect_taken = 1'b1;
        redirect_addr  = addr;
        new_seq(aligned);
        @(negedge clk);
        exp_disc += mq_addr.size() + int'(imem_rsp_valid);
        chk("redir_if_valid", 32'(if_valid), 0);
        chk("redir_req_valid", 32'(imem_req_valid), 0);
        @(posedge clk); #1;
        redirect_taken = 1'b0;
        @(negedge clk);
        chk("post_redir_empty", 32'(if_valid), 0);
        chk("post_redir_addr", imem_req_addr, aligned);
    endtask

    // memory: accepts requests sampled mid-cycle, answers in order after lat cycles
    initial begin
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rst_n) begin
                mq_addr.delete();
                mq_due.delete();
                imem_rsp_valid = 1'b0;
            end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            imem_req_ready = rdy_toggle ? cyc[0] : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
        end
    end

    always @(negedge clk) begin
        if (if_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty got=%h want=none", if_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("out_pc", if_pc, e);
                chk("out_instr", if_instr, instr_of(e));
                chk("out_pc4", if_pc_plus4, e + 32'd4);
            end
            pops++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int s;
        redirect_taken = 1'b0;
        redirect_addr  = '0;
        id_ready       = 1'b1;
        new_seq(32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot_req_valid", 32'(imem_req_valid), 0);
        @(negedge clk);
        chk("first_req_valid", 32'(imem_req_valid), 1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        wait_pops(4);
        s = pops;
        repeat (8) begin @(posedge clk); #1; end
        chk("throughput", 32'(pops - s), 8);

        id_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_head", if_pc, exp_q[0]);
        end
        chk("stall_if_valid", 32'(if_valid), 1);
        chk("stall_req_valid", 32'(imem_req_valid), 0);
        @(posedge clk); #1;
        id_ready = 1'b1;
        wait_pops(8);

        lat = 3;
        wait_pops(6);
        do_redirect(32'h100, 32'h100);
        wait_pops(6);

        do_redirect(32'h203, 32'h200);
        wait_pops(4);

        lat = 1;
        wait_pops(6);
        do_redirect(32'h300, 32'h300);
        @(negedge clk);
        chk("sim_c2_empty", 32'(if_valid), 0);
        @(negedge clk);
        chk("sim_c3_valid", 32'(if_valid), 1);
        wait_pops(4);

`ifdef IFU_PERF_EN
        chk("perf_discarded", perf_discarded, 32'(exp_disc));
`endif

        rdy_toggle = 1'b1;
        lat = 3;
        wait_pops(10);
        @(posedge clk); #3;
        rst_n = 1'b0;
        new_seq(32'h0);
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot2_req_valid", 32'(imem_req_valid), 0);
        @(negedge clk);
        chk("restart_req_valid", 32'(imem_req_valid), 1);
        chk("restart_req_addr", imem_req_addr, 32'h0);
        wait_pops(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction fetch stage with a prefetch queue. It sits directly upstream of the IF/ID pipeline register and produces if_pc, if_instr and if_pc_plus4.
- Issues sequential fetch requests to a valid/ready instruction memory and buffers in-order responses in a small FIFO.
- Presents buffered instructions to decode with a valid/ready handshake.
- On an EX-stage redirect (branch/jump), flushes the queue and discards stale in-flight responses.

Parameters:
- ADDR_WIDTH, 32, PC / memory address width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch queue entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- redirect_taken  in  1  EX-stage branch/jump taken; flush request
- redirect_addr  in  ADDR_WIDTH  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_WIDTH  fetch address, word aligned
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance
- imem_rsp_data  in  DATA_WIDTH  fetched instruction
- id_ready  in  1  downstream accepts instruction (0 = stall)
- if_valid  out  1  instruction at queue head valid
- if_pc  out  ADDR_WIDTH  PC of head instruction
- if_instr  out  DATA_WIDTH  head instruction
- if_pc_plus4  out  ADDR_WIDTH  if_pc + 4

Behaviour:
- Clock and reset: clk and rst_n only; reset is asynchronous, active-low.
- Reset values:
  - fetch_pc = RESET_PC; rsp_pc = RESET_PC.
  - Queue empty; outstanding = 0; discard_cnt = 0; state = BOOT.
  - imem_req_valid = 0, if_valid = 0, if_pc / if_instr / if_pc_plus4 = 0.
- FSM states:
  - BOOT: one cycle after reset release; no requests; moves to RUN.
  - RUN: normal operation.
  - FLUSH: discard_cnt != 0; moves to RUN the cycle discard_cnt reaches 0.
  - redirect_taken in RUN or FLUSH: goes to FLUSH if the computed discard count is nonzero, otherwise to RUN.
- Request issue:
  - imem_req_valid = (state != BOOT) & !redirect_taken & (outstanding + count < FIFO_DEPTH). This credit check makes overflow impossible.
  - imem_req_addr = fetch_pc.
  - req_fire = valid & ready. On req_fire: fetch_pc += 4, outstanding += 1.
  - Address stays stable while valid is held and ready is low.
- Response handling:
  - Every imem_rsp_valid decrements outstanding.
  - If discard_cnt != 0: response dropped, discard_cnt -= 1.
  - Otherwise push {rsp_pc, imem_rsp_data} and rsp_pc += 4.
- Output:
  - if_valid = (count != 0) & !redirect_taken.
  - Head fields drive if_pc / if_instr, driven combinationally from the queue head; they are zero when empty.
  - Pop when if_valid & id_ready. Head is held stable while stalled.
- Simultaneous push and pop: allowed in the same cycle, count unchanged. A push into an empty queue is visible as if_valid the next cycle (response-to-output latency 1 cycle).
- Redirect cycle:
  - Queue cleared; any response arriving that cycle is discarded.
  - fetch_pc and rsp_pc ← {redirect_addr[ADDR_WIDTH-1:2], 2'b00}.
  - discard_cnt ← outstanding − imem_rsp_valid.
  - The first post-redirect request is issued the next cycle.
- Back-to-back redirects: the later one wins; discard_cnt is recomputed from the current outstanding count.
- Arithmetic: PC arithmetic wraps modulo 2^ADDR_WIDTH. Counters are $clog2(FIFO_DEPTH)+1 bits wide.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset for pre-reset requests are a memory-side error and need not be handled.

Optional Feature:
- Macro: IFU_PERF_EN.
- With IFU_PERF_EN defined, three extra outputs are added:
  - perf_fetched [31:0]: counts pushes.
  - perf_discarded [31:0]: counts dropped responses.
  - perf_stall [31:0]: counts cycles with if_valid & !id_ready.
  - All three reset to 0 and saturate at 32'hFFFF_FFFF.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, ready=1, 1-cycle memory, id_ready=1 → first request addr 0x0 in the cycle after BOOT; outputs pc 0x0, 0x4, 0x8… one per cycle; if_pc_plus4 = if_pc+4.
- id_ready=0 for 10 cycles → exactly FIFO_DEPTH=4 responses buffered; imem_req_valid drops once outstanding+count=4; head held at the same pc/instr; no loss when id_ready returns.
- Two requests in flight (to 0x10, 0x14), redirect to 0x100 → both responses dropped; next output pc 0x100; perf_discarded=2 when IFU_PERF_EN defined.
- Redirect to 0x203 → imem_req_addr 0x200; if_pc 0x200.
- Redirect in the same cycle as a response and a pop → if_valid=0 that cycle; response discarded; queue empty next cycle.
- imem_req_ready toggling 0/1 with 3-cycle response latency, plus an asynchronous rst_n pulse mid-stream → in-order PCs with no duplicates before the pulse; all outputs 0 immediately on reset; fetch restarts at RESET_PC.
